// File: rtl/tracer_host_driver_pkg.sv
// tracer_host_pkg: shared types, widths and sizing helpers for the tracer host driver.
// Exports: state_t (driver FSM states), NIBBLE_W, RESULT_W, nibbles(), max3().
package tracer_host_pkg;

    localparam int NIBBLE_W = 4;
    localparam int RESULT_W = 8;

    typedef enum logic [2:0] {IDLE, RST, SEND, WAIT, HOLD} state_t;

    function automatic int nibbles(input int word_w, input int words);
        return word_w * words / NIBBLE_W;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction

endpackage

// File: rtl/tracer_host_driver_if.sv
// tracer_host_driver_if: operand-frame and result streams between a controller and the driver.
// Signals: s_valid/s_ready/s_data/s_abs (frame in), m_valid/m_ready/m_result (result out).
// Modports: master = controller side, slave = driver side.
interface tracer_host_driver_if #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 2
);
    import tracer_host_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic [WORD_W*WORDS-1:0]  s_data;
    logic                     s_abs;
    logic                     m_valid;
    logic                     m_ready;
    logic [RESULT_W-1:0]      m_result;

    modport master (
        output s_valid, s_data, s_abs, m_ready,
        input  s_ready, m_valid, m_result
    );

    modport slave (
        input  s_valid, s_data, s_abs, m_ready,
        output s_ready, m_valid, m_result
    );

endinterface

// File: rtl/tracer_host_driver_shifter.sv
// tracer_nibble_shifter: frame register that loads in parallel and shifts out MSB-first by nibbles.
// Ports: clk, reset_n (async active-low), load (capture din), shift (move left one nibble),
//        din (frame), top_nib (current most-significant nibble).
module tracer_nibble_shifter
    import tracer_host_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                shift,
    input  logic [W-1:0]        din,
    output logic [NIBBLE_W-1:0] top_nib
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= q << NIBBLE_W;
    end

    assign top_nib = q[W-1 -: NIBBLE_W];

endmodule

// File: rtl/tracer_host_driver.sv
// tracer_host_driver: accepts an operand frame, resets the tracer, streams the frame in as nibbles and returns its result.
// Ports: clk, reset_n (async active-low), bus (slave side of the frame/result streams),
//        tr_reset/tr_abs/tr_data (to tracer pins), tr_result (from tracer), busy (not IDLE).
module tracer_host_driver
    import tracer_host_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int WORDS       = 2,
    parameter int RESET_CYC   = 2,
    parameter int RESULT_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tracer_host_driver_if.slave   bus,
    output logic                  tr_reset,
    output logic                  tr_abs,
    output logic [NIBBLE_W-1:0]   tr_data,
    input  logic [RESULT_W-1:0]   tr_result,
    output logic                  busy
);

    localparam int N     = nibbles(WORD_W, WORDS);
    localparam int CW    = $clog2(max3(RESET_CYC, N, RESULT_WAIT) + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [NIBBLE_W-1:0]   top_nib;
    logic                  last;
    logic                  accept;
    logic                  shift;

    assign last         = cnt == '0;
    assign bus.s_ready  = reset_n && state == IDLE;
    assign accept       = bus.s_valid && bus.s_ready;
    assign busy         = state != IDLE;
    // The shifter advances whenever a nibble is handed to tr_data, so its top is always the next nibble.
    assign shift        = (state == RST && last) || (state == SEND && !last);

    tracer_nibble_shifter #(.W(WORD_W*WORDS)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .shift   (shift),
        .din     (bus.s_data),
        .top_nib (top_nib)
    );

    // One down-counter is reused for the reset hold, nibble count and result wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            tr_reset     <= 1'b1;
            tr_abs       <= 1'b0;
            tr_data      <= '0;
            bus.m_valid  <= 1'b0;
            bus.m_result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    tr_abs <= bus.s_abs;
                    cnt    <= CW'(RESET_CYC - 1);
                    state  <= RST;
                end
                RST: if (last) begin
                    tr_reset <= 1'b0;
                    tr_data  <= top_nib;
                    cnt      <= CW'(N - 1);
                    state    <= SEND;
                end else
                    cnt <= cnt - 1'b1;
                SEND: if (last) begin
                    tr_data <= '0;
                    cnt     <= CW'(RESULT_WAIT - 1);
                    state   <= WAIT;
                end else begin
                    tr_data <= top_nib;
                    cnt     <= cnt - 1'b1;
                end
                WAIT: if (last) begin
                    bus.m_result <= tr_result;
                    bus.m_valid  <= 1'b1;
                    state        <= HOLD;
                end else
                    cnt <= cnt - 1'b1;
                HOLD: if (bus.m_ready) begin
                    bus.m_valid <= 1'b0;
                    tr_reset    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tracer_host_driver.sv
// tb_tracer_host_driver: directed self-checking bench for tracer_host_driver with default parameters.
module tb_tracer_host_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tr_reset;
    logic       tr_abs;
    logic [3:0] tr_data;
    logic [7:0] tr_result;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    tracer_host_driver_if #(.WORD_W(16), .WORDS(2)) bus ();

    tracer_host_driver #(
        .WORD_W(16), .WORDS(2), .RESET_CYC(2), .RESULT_WAIT(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .tr_reset  (tr_reset),
        .tr_abs    (tr_abs),
        .tr_data   (tr_data),
        .tr_result (tr_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepts one frame and follows it edge by edge up to the result, with m_ready held low.
    task automatic frame(input logic [31:0] d, input logic a, input logic [7:0] res);
        int w = 0;
        while (!bus.s_ready && w < 10) begin
            tick;
            w++;
        end
        check("s_ready_before_accept", bus.s_ready, 1);
        bus.s_data  = d;
        bus.s_abs   = a;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b0;
        tick;
        bus.s_valid = 1'b0;
        bus.s_data  = ~d;
        bus.s_abs   = ~a;
        check("tr_reset_e0", tr_reset, 1);
        check("tr_abs_e0", tr_abs, a);
        check("busy_e0", busy, 1);
        check("s_ready_e0", bus.s_ready, 0);
        check("tr_data_e0", tr_data, 0);
        for (int e = 1; e <= 18; e++) begin
            if (e == 18)
                tr_result = res;
            tick;
            tr_result = 8'hFF;
            if (e == 1)
                check("tr_reset_e1", tr_reset, 1);
            else if (e <= 9) begin
                check("nibble", tr_data, (d >> (4 * (9 - e))) & 32'hF);
                check("tr_reset_send", tr_reset, 0);
            end else if (e <= 17) begin
                check("tr_data_wait", tr_data, 0);
                check("m_valid_early", bus.m_valid, 0);
            end else begin
                check("m_valid_rise", bus.m_valid, 1);
                check("m_result", bus.m_result, res);
                check("tr_abs_hold", tr_abs, a);
            end
        end
    endtask

    task automatic drain;
        bus.m_ready = 1'b1;
        tick;
        bus.m_ready = 1'b0;
        check("drain_m_valid", bus.m_valid, 0);
        check("drain_s_ready", bus.s_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first;
        int second;
        logic seen;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_abs   = 1'b0;
        bus.m_ready = 1'b0;
        tr_result   = 8'hFF;
        repeat (3) tick;
        check("rst_tr_reset", tr_reset, 1);
        check("rst_tr_abs", tr_abs, 0);
        check("rst_tr_data", tr_data, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_result", bus.m_result, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick;
        check("s_ready_after_reset", bus.s_ready, 1);

        frame(32'h1234_ABCD, 1'b0, 8'h5A);

        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
        bus.s_abs   = 1'b1;
        repeat (10) begin
            tick;
            check("bp_m_valid", bus.m_valid, 1);
            check("bp_m_result", bus.m_result, 8'h5A);
            check("bp_s_ready", bus.s_ready, 0);
            check("bp_tr_data", tr_data, 0);
            check("bp_tr_abs", tr_abs, 0);
        end
        bus.m_ready = 1'b1;
        tick;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        check("bp_release_m_valid", bus.m_valid, 0);
        check("bp_release_s_ready", bus.s_ready, 1);
        check("bp_release_abs", tr_abs, 0);

        frame(32'h0F0F_5A5A, 1'b1, 8'h3C);
        drain;
        repeat (3) begin
            tick;
            check("abs_idle_keep", tr_abs, 1);
        end
        frame(32'h8765_4321, 1'b0, 8'hC3);
        drain;

        bus.s_data  = 32'hCAFE_F00D;
        bus.s_abs   = 1'b0;
        bus.s_valid = 1'b1;
        tick;
        bus.s_valid = 1'b0;
        repeat (5) tick;
        check("mid_nibble3", tr_data, 4'hE);
        reset_n = 1'b0;
        #1;
        check("mid_tr_reset", tr_reset, 1);
        check("mid_tr_data", tr_data, 0);
        check("mid_busy", busy, 0);
        check("mid_m_valid", bus.m_valid, 0);
        tick;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            tick;
            seen = seen | bus.m_valid;
        end
        check("mid_no_m_valid", seen, 0);
        frame(32'h1357_9BDF, 1'b0, 8'h81);
        drain;

        first  = -1;
        second = -1;
        bus.m_ready = 1'b1;
        bus.s_data  = 32'h1111_2222;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 60 && second < 0; c++) begin
            if (bus.s_ready) begin
                if (first < 0)
                    first = c;
                else
                    second = c;
            end
            tick;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        check("b2b_period", second - first, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tracer_host_driver.md
# tracer_host_driver

Host-side driver for the `algofoogle_tracer` pin interface. It accepts an operand frame over a valid/ready stream and holds the tracer in reset for a minimum period. It then streams the frame into the tracer's 4-bit data pins one nibble per clock, MSB first. After a fixed compute delay it captures the tracer's 8-bit result and returns it on a valid/ready result stream. It sits between an on-chip or FPGA-side controller and the tracer's `io_in`/`io_out` pins.

## Interface

Parameters:
- `WORD_W`, 16: operand width in bits; multiple of 4.
- `WORDS`, 2: operands per frame.
- `RESET_CYC`, 2: minimum tracer reset cycles per frame; ≥1.
- `RESULT_WAIT`, 8: cycles between the last nibble and result capture; ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  operand frame valid.
- `s_ready`  out  1  frame accepted on `s_valid & s_ready`.
- `s_data`  in  WORD_W*WORDS  frame; word 0 in the MSBs.
- `s_abs`  in  1  tracer `abs` mode for this frame.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed on `m_valid & m_ready`.
- `m_result`  out  8  captured tracer result.
- `tr_reset`  out  1  to tracer reset pin; active-high.
- `tr_abs`  out  1  to tracer `abs` pin.
- `tr_data`  out  4  to tracer `i_data` pins.
- `tr_result`  in  8  from tracer `io_out`.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- N = WORDS*WORD_W/4 nibbles per frame. Defaults give N = 8.
- Reset values: state IDLE, `tr_reset`=1, `tr_abs`=0, `tr_data`=0, `m_valid`=0, `m_result`=0, `busy`=0. `s_ready` is 1 once reset deasserts.
- FSM states: IDLE, RST, SEND, WAIT, HOLD.
  - IDLE: `s_ready`=1, `tr_reset`=1. On handshake, latch `s_data` into the shift register and `s_abs` into `tr_abs`, then go to RST.
  - RST: `tr_reset`=1 for RESET_CYC cycles, then go to SEND.
  - SEND: `tr_reset`=0. `tr_data` = top nibble of the shift register; shift left 4 each cycle. After N cycles, go to WAIT.
  - WAIT: `tr_data`=0. Count RESULT_WAIT cycles. On the last count edge, register `tr_result` into `m_result`, set `m_valid`=1 and go to HOLD.
  - HOLD: `m_valid` and `m_result` hold stable until `m_ready`. On handshake, clear `m_valid` and go to IDLE.
- `tr_abs` holds its latched value from accept through HOLD. It is not cleared on return to IDLE.
- `tr_data` is 0 in every state except SEND.
- `s_ready` is 0 outside IDLE; `s_valid` in those states is ignored.
- There is no same-cycle result-drain/accept overlap. `s_ready` rises the cycle after the result handshake.
- Changes to `s_data`/`s_abs` after the accept edge have no effect on the frame in flight.
- Reset mid-operation: the frame is dropped, outputs immediately take their reset values, and no `m_valid` is produced.

## Timing

- Accept at edge k. `tr_reset` stays 1 through edge k+RESET_CYC.
- Nibble i (0..N-1) is driven in the cycle after edge k+RESET_CYC+i.
- `m_valid` rises at edge k+RESET_CYC+N+RESULT_WAIT. With defaults this is k+18.
- `tr_result` is sampled exactly once per frame, at that same edge.
- Minimum frame period is RESET_CYC+N+RESULT_WAIT+2 cycles, which is 20 with defaults and `m_ready` tied high.

## Structure

- Package `tracer_host_pkg` contains:
  - the state enum (IDLE/RST/SEND/WAIT/HOLD);
  - `NIBBLE_W`=4 and `RESULT_W`=8;
  - a function for N from WORD_W and WORDS.
- One sub-module, `tracer_nibble_shifter`: parallel load, shift-by-4, and top-nibble output, with width WORD_W*WORDS.
- The FSM and counters live in the top module. Use one shared down-counter sized for max(RESET_CYC, N, RESULT_WAIT).

## Test plan

- **Nibble order and first frame:** defaults, `s_data`=32'h1234_ABCD, `s_abs`=0.
  - `tr_reset`=1 for 2 cycles after accept.
  - `tr_data` = 1,2,3,4,A,B,C,D on 8 consecutive cycles, then 0.
- **Result capture:** model drives `tr_result`=8'h5A only at the capture edge and 8'hFF otherwise.
  - `m_result`=8'h5A and `m_valid` rises exactly 18 edges after accept.
- **Backpressure:** hold `m_ready`=0 for 10 cycles with `s_valid`=1 and new data.
  - `m_valid`/`m_result` stay stable, `s_ready`=0, and no second frame starts.
  - After `m_ready` pulses, `s_ready`=1 on the next cycle.
- **Abs propagation:** frame with `s_abs`=1.
  - `tr_abs`=1 from the cycle after accept through HOLD.
  - It stays 1 in IDLE until the next frame with `s_abs`=0.
- **Mid-frame reset:** assert `reset_n`=0 during SEND nibble 3.
  - Outputs immediately take reset values (`tr_reset`=1, `tr_data`=0).
  - No `m_valid` appears, and a new frame afterwards runs normally.
- **Back-to-back:** two frames with `m_ready` tied 1.
  - The second accept occurs exactly 20 cycles after the first.
